// File: rtl/collatz_host_ctrl.sv
// Host-side initiator for the byte-wide Collatz accelerator: writes a seed, kicks a job,
// waits for busy to drop (or times out), then reads orbit length and path record back.
module collatz_host_ctrl #(
    parameter int BITS        = 32,
    parameter int N_BYTES     = BITS / 8,
    parameter int READ_LAT    = 2,
    parameter int START_GUARD = 2,
    parameter int TIMEOUT     = 65535
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [BITS-1:0] seed,
    output logic            ready,
    output logic            done,
    output logic            timeout,
    output logic [BITS-1:0] orbit_len,
    output logic [BITS-1:0] path_rec,
    output logic [7:0]      dev_data_out,
    output logic [7:0]      dev_ctrl_out,
    input  logic [7:0]      dev_data_in,
    input  logic            dev_busy
);

    localparam int IW = $clog2(2 * N_BYTES + 1);
    localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT + 1) : 1;
    localparam int CW = $clog2(TIMEOUT + START_GUARD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_KICK,
        S_GUARD,
        S_WAIT,
        S_READ,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [BITS-1:0] r_shift;
    logic [IW-1:0]   r_idx;
    logic [LW-1:0]   r_lat;
    logic [CW-1:0]   r_cnt;
    logic [6:0]      w_lane;

    // Orbit bytes live at 0..N_BYTES-1, path bytes at 16..16+N_BYTES-1.
    function automatic logic [4:0] rd_addr(input logic [IW-1:0] idx);
        if (idx < IW'(N_BYTES))
            return 5'(idx);
        return 5'd16 + 5'(idx - IW'(N_BYTES));
    endfunction

    assign w_lane = {dev_ctrl_out[3:0], 3'b000};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_idx        <= '0;
            r_lat        <= '0;
            r_cnt        <= '0;
            ready        <= 1'b1;
            done         <= 1'b0;
            timeout      <= 1'b0;
            orbit_len    <= '0;
            path_rec     <= '0;
            dev_data_out <= 8'h00;
            dev_ctrl_out <= 8'h80;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        dev_data_out <= seed[7:0];
                        dev_ctrl_out <= 8'h00;
                        r_shift      <= seed >> 8;
                        r_idx        <= '0;
                        timeout      <= 1'b0;
                        orbit_len    <= '0;
                        path_rec     <= '0;
                        ready        <= 1'b0;
                        r_state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (r_idx == IW'(N_BYTES - 1)) begin
                        dev_ctrl_out <= 8'hC0;
                        dev_data_out <= 8'h00;
                        r_state      <= S_KICK;
                    end else begin
                        r_idx        <= r_idx + IW'(1);
                        dev_ctrl_out <= {3'b000, 5'(r_idx + IW'(1))};
                        dev_data_out <= r_shift[7:0];
                        r_shift      <= r_shift >> 8;
                    end
                end
                S_KICK: begin
                    dev_ctrl_out <= 8'h80;
                    r_cnt        <= '0;
                    r_state      <= (START_GUARD == 0) ? S_WAIT : S_GUARD;
                end
                S_GUARD: begin
                    if (r_cnt == CW'(START_GUARD - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (!dev_busy) begin
                        r_idx        <= '0;
                        r_lat        <= '0;
                        dev_ctrl_out <= {3'b100, rd_addr('0)};
                        r_state      <= S_READ;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_READ: begin
                    if (r_lat == LW'(READ_LAT - 1)) begin
                        if (dev_ctrl_out[4])
                            path_rec[w_lane +: 8] <= dev_data_in;
                        else
                            orbit_len[w_lane +: 8] <= dev_data_in;
                        r_lat <= '0;
                        if (r_idx == IW'(2 * N_BYTES - 1)) begin
                            dev_ctrl_out <= 8'h80;
                            done         <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_idx        <= r_idx + IW'(1);
                            dev_ctrl_out <= {3'b100, rd_addr(r_idx + IW'(1))};
                        end
                    end else begin
                        r_lat <= r_lat + LW'(1);
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_collatz_host_ctrl.sv
// Directed bench for collatz_host_ctrl with a behavioural accelerator and a bus monitor.
module tb_collatz_host_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] seed;
    logic        ready, done, timeout;
    logic [31:0] orbit_len, path_rec;
    logic [7:0]  dev_data_out, dev_ctrl_out;
    logic [7:0]  dev_data_in = 8'h00;
    logic        dev_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // accelerator model configuration
    logic [31:0] m_orbit = '0;
    logic [31:0] m_path  = '0;
    int          m_busy_n = 0;
    logic        m_forever = 1'b0;
    int          m_bcnt = 0;

    // bus monitor state
    int          wr_cnt = 0, kick_cnt = 0, rd_cnt = 0, bad_cnt = 0, done_cnt = 0;
    logic [63:0] wr_sig = '0;
    int          s_wr, s_kick, s_rd, s_done;
    int          lat;

    collatz_host_ctrl #(.TIMEOUT(100)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .seed         (seed),
        .ready        (ready),
        .done         (done),
        .timeout      (timeout),
        .orbit_len    (orbit_len),
        .path_rec     (path_rec),
        .dev_data_out (dev_data_out),
        .dev_ctrl_out (dev_ctrl_out),
        .dev_data_in  (dev_data_in),
        .dev_busy     (dev_busy)
    );

    always #5 clk = ~clk;

    assign dev_busy = m_forever || (m_bcnt != 0);

    always @(posedge clk) begin
        logic [4:0] a;
        a = dev_ctrl_out[4:0];
        if (dev_ctrl_out[6])
            m_bcnt <= m_busy_n;
        else if (m_bcnt != 0)
            m_bcnt <= m_bcnt - 1;
        if (a < 5'd4)
            dev_data_in <= m_orbit[{a[1:0], 3'b000} +: 8];
        else if (a >= 5'd16 && a < 5'd20)
            dev_data_in <= m_path[{a[1:0], 3'b000} +: 8];
        else
            dev_data_in <= 8'h00;
    end

    always @(posedge clk) begin
        if (!dev_ctrl_out[7]) begin
            wr_cnt <= wr_cnt + 1;
            wr_sig <= {wr_sig[47:0], dev_ctrl_out, dev_data_out};
            if (dev_ctrl_out[6:5] != 2'b00)
                bad_cnt <= bad_cnt + 1;
        end
        if (dev_ctrl_out[6])
            kick_cnt <= kick_cnt + 1;
        if (dev_ctrl_out[7] && dev_ctrl_out[4:0] != 5'd0)
            rd_cnt <= rd_cnt + 1;
        if (done)
            done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s_wr   = wr_cnt;
        s_kick = kick_cnt;
        s_rd   = rd_cnt;
        s_done = done_cnt;
    endtask

    // Caller is #1 after a clock edge with ready=1; returns #1 after the done edge.
    task automatic run_job(input logic [31:0] s, input int budget, output int l);
        start = 1'b1;
        seed  = s;
        @(posedge clk); #1;
        start = 1'b0;
        l = 1;
        while (!done && l < budget) begin
            @(posedge clk); #1;
            l++;
        end
        check_eq("done_seen", done, 1);
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        seed  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", ready, 1);
        check_eq("rst_done", done, 0);
        check_eq("rst_timeout", timeout, 0);
        check_eq("rst_orbit", orbit_len, 0);
        check_eq("rst_path", path_rec, 0);
        check_eq("rst_ctrl", dev_ctrl_out, 8'h80);
        check_eq("rst_data", dev_data_out, 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // seed 27 with a 10-cycle busy window
        m_orbit = 32'd111; m_path = 32'd9232; m_busy_n = 10;
        snap();
        run_job(32'h0000_001B, 200, lat);
        check_eq("t1_lat", lat, 33);
        check_eq("t1_orbit", orbit_len, 32'h0000_006F);
        check_eq("t1_path", path_rec, 32'h0000_2410);
        check_eq("t1_timeout", timeout, 0);
        settle();
        check_eq("t1_wr_sig", wr_sig, 64'h001B_0100_0200_0300);
        check_eq("t1_wr_cnt", wr_cnt - s_wr, 4);
        check_eq("t1_kick", kick_cnt - s_kick, 1);
        check_eq("t1_rd_cnt", rd_cnt - s_rd, 14);
        check_eq("t1_ready", ready, 1);

        // busy already low: nominal latency, distinct byte lanes
        m_orbit = 32'hA1B2_C3D4; m_path = 32'h0F1E_2D3C; m_busy_n = 0;
        run_job(32'h1234_5678, 100, lat);
        check_eq("t2_lat", lat, 25);
        check_eq("t2_orbit", orbit_len, 32'hA1B2_C3D4);
        check_eq("t2_path", path_rec, 32'h0F1E_2D3C);
        settle();
        check_eq("t2_wr_sig", wr_sig, 64'h0078_0156_0234_0312);

        // extra start pulses mid-job and on the done cycle are dropped
        snap();
        start = 1'b1;
        seed  = 32'hCAFE_F00D;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 2; c <= 60; c++) begin
            @(posedge clk); #1;
            start = (c == 3 || c == 12 || done);
        end
        start = 1'b0;
        check_eq("t3_done_cnt", done_cnt - s_done, 1);
        check_eq("t3_kick", kick_cnt - s_kick, 1);
        check_eq("t3_wr_cnt", wr_cnt - s_wr, 4);
        check_eq("t3_rd_cnt", rd_cnt - s_rd, 14);
        check_eq("t3_wr_sig", wr_sig, 64'h000D_01F0_02FE_03CA);
        check_eq("t3_orbit", orbit_len, 32'hA1B2_C3D4);

        // busy never drops
        m_forever = 1'b1;
        snap();
        run_job(32'h0000_0007, 300, lat);
        check_eq("t4_lat", lat, 108);
        check_eq("t4_timeout", timeout, 1);
        check_eq("t4_orbit", orbit_len, 0);
        check_eq("t4_path", path_rec, 0);
        settle();
        check_eq("t4_rd_cnt", rd_cnt - s_rd, 0);
        check_eq("t4_ready", ready, 1);
        m_forever = 1'b0;

        // reset in the middle of the read phase
        start = 1'b1;
        seed  = 32'h0000_0055;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("t5_timeout_clr", timeout, 0);
        repeat (11) @(posedge clk);
        #1;
        check_eq("t5_partial", orbit_len, 32'h0000_00D4);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("t5_ready", ready, 1);
        check_eq("t5_ctrl", dev_ctrl_out, 8'h80);
        check_eq("t5_orbit", orbit_len, 0);
        check_eq("t5_path", path_rec, 0);
        check_eq("t5_done", done, 0);
        rst_n = 1'b1;
        m_orbit = 32'd111; m_path = 32'd9232; m_busy_n = 3;
        run_job(32'h0000_001B, 200, lat);
        check_eq("t5_job_orbit", orbit_len, 32'h0000_006F);
        check_eq("t5_job_path", path_rec, 32'h0000_2410);
        settle();

        check_eq("bus_bad", bad_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
